sram: RTL and testbench
=======================

SRAM -- requirements
Module: sram

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 10: width of read and write addresses.
REQ-003 Parameter DEPTH, default 1024: number of words, with 1 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 clk  input  1: single clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 wen  input  1: write enable, sampled on the rising clk edge.
REQ-007 wadr  input  ADDR_WIDTH: write address.
REQ-008 wdata  input  DATA_WIDTH: write data.
REQ-009 ren  input  1: read enable, sampled on the rising clk edge.
REQ-010 radr  input  ADDR_WIDTH: read address.
REQ-011 rdata  output  DATA_WIDTH: registered read data.

Function
REQ-012 The block SHALL be a one-read-port, one-write-port memory of DEPTH x DATA_WIDTH, with both ports usable in the same cycle.
- Write: on a rising edge with wen=1 and wadr<DEPTH, mem[wadr] <= wdata; the valid bit for wadr is set.
REQ-013 Read: on a rising edge with ren=1, rdata SHALL be updated with the word at radr, giving 1-cycle latency.
REQ-014 With ren=0, rdata SHALL hold its last value, including across writes to any address.
REQ-015 The block SHALL keep a DEPTH-bit valid vector; a read of a location never written since reset SHALL return 0.
REQ-016 Writes with wadr>=DEPTH SHALL be ignored, and reads with radr>=DEPTH SHALL return 0.
REQ-017 Simultaneous read and write to different addresses SHALL be independent.
- Simultaneous read and write to the same address: behaviour is set by REQ-022/023.
REQ-018 Enable inputs with X/Z values are not supported; the bench SHALL drive wen and ren to known values at all times outside reset.

Reset
REQ-019 While rst_n=0, rdata SHALL be 0 and all valid bits SHALL be cleared, taking effect immediately without waiting for a clock edge.
REQ-020 Memory array contents are not reset; after reset they are unobservable because the valid bits are cleared.
REQ-021 Reset asserted mid-operation SHALL abort any write in that cycle, and after reset deassertion the first write SHALL be accepted on the next rising edge.

Configuration
REQ-022 With macro SRAM_WR_BYPASS_EN defined: a same-cycle read and write to the same valid address SHALL return the new wdata on rdata.
REQ-023 With SRAM_WR_BYPASS_EN undefined: a same-cycle read and write to the same address SHALL return the old content, or 0 if the location was not yet valid.
- The written data SHALL be visible from the next cycle on.

Verification
REQ-024 Reset, then write 137 to address 97 with no read -> rdata=0 after the write edge.
REQ-025 Write 137 to address 97, then read 97 -> rdata=137 one cycle later; it stays 137 with ren=0 while 84 is written to address 83.
REQ-026 Read 83 -> 84, then write 39 to address 4 -> rdata stays 84; then read 4 -> 39.
REQ-027 After reset, read address 5 (never written) -> 0; read address 97 after re-reset -> 0.
REQ-028 Same-cycle write 55 and read at address 10, which holds 7 -> rdata=55 with SRAM_WR_BYPASS_EN, otherwise 7; the next read of 10 -> 55 in both builds.
REQ-029 Assert rst_n=0 between clock edges while rdata=39 -> rdata=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sram.sv
// One-read/one-write DEPTH x DATA_WIDTH memory with a per-word valid vector and a registered read port.
// Optional macro SRAM_WR_BYPASS_EN: a same-cycle read of the word being written returns the new write data.
module sram #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] wadr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] radr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]      valid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [DATA_WIDTH-1:0] rdata_next_s;
   logic                  wr_in_range_s;
   logic                  rd_in_range_s;
   logic                  wr_accept_s;
   logic                  bypass_hit_s;
   logic [IDX_W-1:0]      wr_idx_s;
   logic [IDX_W-1:0]      rd_idx_s;

   assign wr_in_range_s = ({1'b0, wadr} < DEPTH_L);
   assign rd_in_range_s = ({1'b0, radr} < DEPTH_L);
   assign wr_idx_s      = wadr[IDX_W-1:0];
   assign rd_idx_s      = radr[IDX_W-1:0];
   // A write seen while reset is held is dropped so it cannot land in the array.
   assign wr_accept_s   = wen & wr_in_range_s & rst_n;

`ifdef SRAM_WR_BYPASS_EN
   assign bypass_hit_s = wr_accept_s & ren & (wadr == radr);
`else
   assign bypass_hit_s = 1'b0;
`endif

   // Next read-data value: load on ren, otherwise hold.
   always_comb begin
      rdata_next_s = rdata_r;
      if (ren) begin
         if (!rd_in_range_s) begin
            rdata_next_s = {DATA_WIDTH{1'b0}};
         end else if (bypass_hit_s) begin
            rdata_next_s = wdata;
         end else if (valid_r[rd_idx_s]) begin
            rdata_next_s = mem_r[rd_idx_s];
         end else begin
            rdata_next_s = {DATA_WIDTH{1'b0}};
         end
      end else begin
         rdata_next_s = rdata_r;
      end
   end

   // Storage array; intentionally unreset, hidden by the valid vector after reset.
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_r[wr_idx_s] <= wdata;
      end
   end

   // Valid vector tracking which words have been written since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {DEPTH{1'b0}};
      end else if (wr_accept_s) begin
         valid_r[wr_idx_s] <= 1'b1;
      end
   end

   // Registered read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         rdata_r <= rdata_next_s;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: tb/tb_sram.sv
// Randomized scoreboard bench for sram: a word-level reference model predicts rdata every cycle.
module tb_sram;

   localparam int DW  = 32;
   localparam int AW  = 7;
   localparam int DEP = 100;
   localparam int NA  = 1 << AW;
`ifdef SRAM_WR_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          wen   = 1'b0;
   logic          ren   = 1'b0;
   logic [AW-1:0] wadr  = '0;
   logic [AW-1:0] radr  = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] m_mem [NA];
   bit            m_val [NA];
   logic [DW-1:0] m_rd;

   always #5 clk = ~clk;

   sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .wen  (wen),
      .wadr (wadr),
      .wdata(wdata),
      .ren  (ren),
      .radr (radr),
      .rdata(rdata)
   );

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Drive one cycle at a falling edge, predict the result and queue it for the monitor.
   task automatic cycle(input bit w, input int wa, input logic [DW-1:0] wd, input bit r, input int ra);
      wen   = w;
      wadr  = AW'(wa);
      wdata = wd;
      ren   = r;
      radr  = AW'(ra);
      if (r) begin
         if (ra >= DEP)                       m_rd = '0;
         else if (BYPASS && w && wa == ra)    m_rd = wd;
         else if (m_val[ra])                  m_rd = m_mem[ra];
         else                                 m_rd = '0;
      end
      if (w && wa < DEP) begin
         m_mem[wa] = wd;
         m_val[wa] = 1'b1;
      end
      exp_q.push_back(m_rd);
      @(negedge clk);
   endtask

   // Assert reset between edges with a write pending, check the immediate clear, release at a falling edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      wen   = 1'b1;
      wadr  = AW'(5);
      wdata = 32'hDEAD_BEEF;
      ren   = 1'b1;
      radr  = AW'(5);
      #1;
      check("reset_immediate", rdata, '0);
      for (int i = 0; i < NA; i++) m_val[i] = 1'b0;
      m_rd = '0;
      @(negedge clk);
      check("reset_hold", rdata, '0);
      @(negedge clk);
      rst_n = 1'b1;
      wen   = 1'b0;
      ren   = 1'b0;
   endtask

   // Monitor: compare rdata after every rising edge against the queued prediction.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            check("rdata", rdata, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NA; i++) begin
         m_val[i] = 1'b0;
         m_mem[i] = '0;
      end
      m_rd = '0;
      @(negedge clk);
      do_reset();

      cycle(1, 97, 32'd137, 0, 0);
      cycle(0, 0, 32'd0, 1, 97);
      cycle(1, 83, 32'd84, 0, 0);
      cycle(0, 0, 32'd0, 1, 83);
      cycle(1, 4, 32'd39, 0, 0);
      cycle(0, 0, 32'd0, 1, 4);
      do_reset();
      cycle(0, 0, 32'd0, 1, 5);
      cycle(0, 0, 32'd0, 1, 97);
      cycle(1, 10, 32'd7, 0, 0);
      cycle(1, 10, 32'd55, 1, 10);
      cycle(0, 0, 32'd0, 1, 10);
      cycle(1, 110, 32'd99, 0, 0);
      cycle(0, 0, 32'd0, 1, 110);
      cycle(1, DEP-1, 32'hA5A5_0001, 0, 0);
      cycle(1, DEP, 32'h1234_5678, 1, DEP-1);
      cycle(0, 0, 32'd0, 1, DEP);
      cycle(1, 20, 32'd11, 1, 20);

      for (int n = 0; n < 2000; n++) begin
         int wa;
         int ra;
         if ($urandom_range(0, 1) == 0) begin
            wa = $urandom_range(0, 15);
            ra = $urandom_range(0, 15);
         end else begin
            wa = $urandom_range(0, NA-1);
            ra = $urandom_range(0, NA-1);
         end
         if (n % 500 == 499) do_reset();
         cycle(bit'($urandom_range(0, 1)), wa, $urandom, bit'($urandom_range(0, 1)), ra);
      end

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) check("drain", DW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
